// File: rtl/uart_rx_fifo_if.sv
// Pop-side and serial-line signals of the UART receive FIFO.
// The slave modport is the receiver; the master modport is the line driver and byte consumer.
interface uart_rx_fifo_if #(
    parameter int CNT_W = 3
) ();
    logic             rxIn;
    logic [7:0]       rdData;
    logic             rdValid;
    logic             rdReady;
    logic [CNT_W-1:0] level;
    logic             frameErr;
    logic             overflow;
    logic             errClr;

    modport master (
        output rxIn, rdReady, errClr,
        input  rdData, rdValid, level, frameErr, overflow
    );

    modport slave (
        input  rxIn, rdReady, errClr,
        output rdData, rdValid, level, frameErr, overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver feeding a small byte FIFO with a valid/ready pop port.
// Sticky frame-error and overflow flags; one divider counter times every sample from the start edge.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input logic           clk,
    input logic           rstn,
    uart_rx_fifo_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [DIV_W-1:0] BIT_LOAD  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    logic             r_sync1;
    logic             r_rx_s;
    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
    logic             r_overflow;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_rd_data;
    logic             r_rd_valid;

    logic             w_tick;
    logic             w_full;
    logic             w_pop;
    logic             w_stop_ok;
    logic             w_stop_bad;
    logic             w_push;
    logic             w_drop;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic [7:0]       w_head_nxt;

    assign w_tick     = (r_div == '0);
    assign w_full     = (r_count == DEPTH_C);
    assign w_pop      = r_rd_valid & bus.rdReady;
    assign w_stop_ok  = (r_state == S_STOP) & w_tick & r_rx_s;
    assign w_stop_bad = (r_state == S_STOP) & w_tick & ~r_rx_s;
    assign w_push     = w_stop_ok & (~w_full | w_pop);
    assign w_drop     = w_stop_ok & w_full & ~w_pop;

    assign bus.rdData   = r_rd_data;
    assign bus.rdValid  = r_rd_valid;
    assign bus.level    = r_count;
    assign bus.frameErr = r_frame_err;
    assign bus.overflow = r_overflow;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= bus.rxIn;
            r_rx_s  <= r_sync1;
        end
    end

    // Frame FSM: the divider is loaded with a half bit at the start edge, then a full bit per sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_div   <= HALF_LOAD;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_DATA;
                            r_div     <= BIT_LOAD;
                            r_bit_idx <= 3'd0;
                        end
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_div   <= BIT_LOAD;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_state <= r_rx_s ? S_IDLE : S_BRK;
                    end else begin
                        r_div <= r_div - DIV_W'(1);
                    end
                end
                S_BRK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Next read pointer, occupancy and head byte after this edge's push/pop.
    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        w_head_nxt   = r_mem[r_rd_ptr];
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
        // A byte pushed into an otherwise-empty FIFO becomes the head without a memory read.
        if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
            w_head_nxt = r_shift;
        end else begin
            w_head_nxt = r_mem[w_rd_ptr_nxt];
        end
    end

    // FIFO storage, pointers and registered head/valid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_rd_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_rd_data <= w_head_nxt;
            end
        end
    end

    // Sticky error flags; a set on the same edge wins over errClr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_stop_bad) begin
                r_frame_err <= 1'b1;
            end else if (bus.errClr) begin
                r_frame_err <= 1'b0;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.errClr) begin
                r_overflow <= 1'b0;
            end
        end
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front-end that sits directly downstream of the Uart peripheral's txOut pin.
- Deserialises 8N1 frames (LSB first) into bytes and buffers them in a small FIFO.
- Presents the buffered bytes to a consumer over a valid/ready pop handshake.
- Used as a loopback checker on the FPGA harness and as a reusable receive stage for the bus-mapped peripheral set.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4.
- FIFO_DEPTH, 4, byte entries; power of two, >= 2.
- CNT_W, 3, width of level output; must hold FIFO_DEPTH (log2(FIFO_DEPTH)+1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rstn  input  1  asynchronous active-low reset.
- rxIn  input  1  raw serial line, idle high; asynchronous to clk.
- rdData  output  8  FIFO head byte; meaningful only while rdValid=1.
- rdValid  output  1  FIFO non-empty.
- rdReady  input  1  consumer pops head when rdValid & rdReady at a clk edge.
- level  output  CNT_W  current FIFO occupancy, 0..FIFO_DEPTH.
- frameErr  output  1  sticky: a frame had a low stop bit.
- overflow  output  1  sticky: a good byte arrived while the FIFO was full.
- errClr  input  1  synchronous clear of frameErr and overflow.

Behaviour:
- Reset values: rdData=0, rdValid=0, level=0, frameErr=0, overflow=0, FSM=IDLE, synchroniser flops=1. Reset takes effect mid-frame or mid-pop with no partial byte retained.
- Input path: rxIn passes through a 2-flop synchroniser; rxS is the second flop. All sampling below uses rxS.
- Timing reference: t0 is the first edge at which the FSM is in IDLE and samples rxS=0. One divider counter runs from t0.
- FSM states: IDLE, START, DATA, STOP, BRK.
- IDLE: on rxS=0 go to START and load the counter.
- START: at t0+CLKS_PER_BIT/2, resample rxS.
  - rxS=1: glitch; return to IDLE, nothing recorded.
  - rxS=0: go to DATA.
- DATA: bit i (i=0..7) is sampled at t0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT and shifted in LSB first. After bit 7, go to STOP.
- STOP: sample at t0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
  - rxS=1 and (FIFO not full, or a pop occurs on the same edge): push the byte; next state IDLE.
  - rxS=1 and FIFO full with no same-edge pop: drop the byte; set overflow; next state IDLE.
  - rxS=0: drop the byte; set frameErr; next state BRK.
- BRK: wait until rxS=1, then go to IDLE. A held-low break yields exactly one frameErr and no bytes.
- Back-to-back frames: IDLE may detect the next start on the edge after the stop sample, so no dead bit time is needed.
- FIFO push/pop:
  - Push is visible the edge after the stop sample: rdValid=1, level incremented.
  - Pop when rdValid & rdReady: head advances; rdData updates on the same edge; level decrements.
  - rdReady with rdValid=0 is ignored.
  - Simultaneous push and pop: level unchanged; both succeed, including when full (no overflow).
  - Pointers wrap modulo FIFO_DEPTH.
  - rdData is registered from the FIFO head and holds its value while rdValid=1 and no pop occurs.
- Sticky flags:
  - Set has priority over errClr when both occur on the same edge.
  - errClr does not affect the FIFO or the FSM.
- Latency (CLKS_PER_BIT=16): 2-cycle synchroniser + 152 cycles from t0 to stop sample + 1 cycle to rdValid.

Test Plan:
- Byte 0xA5 sent at 16 clk/bit, rdReady=0 -> rdValid=1 with rdData=0xA5 and level=1, one cycle after the stop sample; pop -> rdValid=0, level=0.
- rxIn low for 5 cycles only (less than CLKS_PER_BIT/2) -> FSM back in IDLE, level=0, no flags set.
- Frame 0x3C with stop bit driven low, line held low 40 cycles, then high -> frameErr=1, level=0; a following 0x81 frame -> level=1, rdData=0x81. errClr -> frameErr=0.
- Five frames 0x01..0x05 with rdReady=0 -> level=4, overflow=1; pops return 0x01, 0x02, 0x03, 0x04.
- FIFO full (4 entries) and rdReady=1 on the 5th frame's stop-sample edge -> 0x05 accepted, overflow=0, level stays 4.
- rstn pulsed low at bit 4 of a frame -> all outputs zero; the next complete frame 0x55 is received correctly.
